mult_share_arb: RTL and testbench

Shares one `multiplier_array_pipe` instance between two requesters.
- Arbitrates operand requests with a valid/ready handshake and drives the multiplier operands.
- Tracks each issued operation's owner through the fixed pipeline latency.
- Steers each product into a per-requester result FIFO with valid/ready drain.
- Sits between two datapath clients and the multiplier; the multiplier stays a separate instance driven through the `mul_*` ports.

---
 rtl/mult_arb_pkg.sv | 30 +++
 rtl/mult_rsp_fifo.sv | 67 ++++++
 rtl/mult_share_arb.sv | 176 +++++++++++++++++
 tb/tb_mult_share_arb.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the two-requester multiplier arbiter.
// Optional build macro MULT_ARB_FIXED_PRIO_EN is consumed by mult_share_arb.
package mult_arb_pkg;

  localparam int BW_DEF     = 8;
  localparam int LAT_DEF    = 8;
  localparam int RDEPTH_DEF = 4;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  localparam int CREDIT_W_DEF = $clog2(RDEPTH_DEF + 1);

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry FIFO still needs a one-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mult_rsp_fifo.sv
// First-word fall-through result FIFO; one instance per requester.
module mult_rsp_fifo
  import mult_arb_pkg::*;
#(
  parameter int bw     = BW_DEF,
  parameter int RDEPTH = RDEPTH_DEF
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            push,
  input  logic [2*bw-1:0] din,
  input  logic            pop,
  output logic [2*bw-1:0] dout,
  output logic            empty,
  output logic            full
);

  localparam int PW   = ptr_width(RDEPTH);
  localparam int CNTW = credit_width(RDEPTH);
  localparam logic [PW-1:0]   LAST_PTR  = PW'(RDEPTH - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(RDEPTH);

  logic [2*bw-1:0] mem [RDEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CNTW-1:0] count;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= ptr_next(wptr);
      end
      if (do_pop) begin
        rptr <= ptr_next(rptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one external pipelined multiplier between two requesters with credit-based result FIFOs.
// Define MULT_ARB_FIXED_PRIO_EN for fixed priority to requester 0; default is round-robin.
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int bw     = BW_DEF,
  parameter int LAT    = LAT_DEF,
  parameter int RDEPTH = RDEPTH_DEF
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [bw-1:0]   req0_A,
  input  logic [bw-1:0]   req0_B,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [bw-1:0]   req1_A,
  input  logic [bw-1:0]   req1_B,
  output logic [bw-1:0]   mul_A,
  output logic [bw-1:0]   mul_B,
  input  logic [2*bw-1:0] mul_out,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [2*bw-1:0] rsp0_data,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [2*bw-1:0] rsp1_data
);

  localparam int CW = credit_width(RDEPTH);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(RDEPTH);

  logic [CW-1:0] credit0;
  logic [CW-1:0] credit1;
  logic          elig0;
  logic          elig1;
  logic          gnt0;
  logic          gnt1;
  logic          issue;
  req_id_t       gnt_id;
  tag_t          tag_pipe [0:LAT];
  logic          push0;
  logic          push1;
  logic          pop0;
  logic          pop1;
  logic          empty0;
  logic          empty1;
  logic          full0;
  logic          full1;

`ifndef MULT_ARB_FIXED_PRIO_EN
  req_id_t       last_grant;
`endif

  assign elig0 = req0_valid && (credit0 != '0);
  assign elig1 = req1_valid && (credit1 != '0);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef MULT_ARB_FIXED_PRIO_EN
    gnt0 = elig0;
    gnt1 = elig1 && !elig0;
`else
    if (elig0 && elig1) begin
      gnt0 = (last_grant == REQ1);
      gnt1 = (last_grant == REQ0);
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end
`endif
  end

  assign issue      = gnt0 || gnt1;
  assign gnt_id     = gnt1 ? REQ1 : REQ0;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      mul_A <= '0;
      mul_B <= '0;
    end else if (issue) begin
      mul_A <= gnt1 ? req1_A : req0_A;
      mul_B <= gnt1 ? req1_B : req0_B;
    end
  end

`ifndef MULT_ARB_FIXED_PRIO_EN
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      last_grant <= REQ1;
    end else if (issue) begin
      last_grant <= gnt_id;
    end
  end
`endif

  // LAT+1 stages: the owner tag sits in the last stage exactly while mul_out
  // holds that operation's product, so the FIFO write lands on edge issue+LAT+1.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i <= LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{valid: issue, id: gnt_id};
      for (int i = 1; i <= LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign push0 = tag_pipe[LAT].valid && (tag_pipe[LAT].id == REQ0);
  assign push1 = tag_pipe[LAT].valid && (tag_pipe[LAT].id == REQ1);

  assign rsp0_valid = !empty0;
  assign rsp1_valid = !empty1;
  assign pop0       = rsp0_valid && rsp0_ready;
  assign pop1       = rsp1_valid && rsp1_ready;

  // A credit is one reserved FIFO slot; it is held from issue until the pop.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      credit0 <= CREDIT_MAX;
      credit1 <= CREDIT_MAX;
    end else begin
      unique case ({gnt0, pop0})
        2'b10:   credit0 <= credit0 - 1'b1;
        2'b01:   credit0 <= credit0 + 1'b1;
        default: credit0 <= credit0;
      endcase
      unique case ({gnt1, pop1})
        2'b10:   credit1 <= credit1 - 1'b1;
        2'b01:   credit1 <= credit1 + 1'b1;
        default: credit1 <= credit1;
      endcase
    end
  end

  mult_rsp_fifo #(
    .bw     (bw),
    .RDEPTH (RDEPTH)
  ) u_fifo0 (
    .CLK    (CLK),
    .RESETn (RESETn),
    .push   (push0),
    .din    (mul_out),
    .pop    (pop0),
    .dout   (rsp0_data),
    .empty  (empty0),
    .full   (full0)
  );

  mult_rsp_fifo #(
    .bw     (bw),
    .RDEPTH (RDEPTH)
  ) u_fifo1 (
    .CLK    (CLK),
    .RESETn (RESETn),
    .push   (push1),
    .din    (mul_out),
    .pop    (pop1),
    .dout   (rsp1_data),
    .empty  (empty1),
    .full   (full1)
  );

  a_credit0_range: assert property (@(posedge CLK) disable iff (!RESETn) credit0 <= CREDIT_MAX);
  a_credit1_range: assert property (@(posedge CLK) disable iff (!RESETn) credit1 <= CREDIT_MAX);
  a_fifo0_space:   assert property (@(posedge CLK) disable iff (!RESETn) !(push0 && full0 && !pop0));
  a_fifo1_space:   assert property (@(posedge CLK) disable iff (!RESETn) !(push1 && full1 && !pop1));

endmodule

// File: tb/tb_mult_share_arb.sv
// Randomized bench for mult_share_arb with a queue-based reference model and a behavioural multiplier.
// Honours MULT_ARB_FIXED_PRIO_EN the same way the design does.
module tb_mult_share_arb;

  localparam int BW     = 8;
  localparam int LAT    = 8;
  localparam int RDEPTH = 4;
  localparam int DW     = 2 * BW;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          req0_valid = 1'b0;
  logic          req0_ready;
  logic [BW-1:0] req0_A = '0;
  logic [BW-1:0] req0_B = '0;
  logic          req1_valid = 1'b0;
  logic          req1_ready;
  logic [BW-1:0] req1_A = '0;
  logic [BW-1:0] req1_B = '0;
  logic [BW-1:0] mul_A;
  logic [BW-1:0] mul_B;
  logic [DW-1:0] mul_out;
  logic          rsp0_valid;
  logic          rsp0_ready = 1'b0;
  logic [DW-1:0] rsp0_data;
  logic          rsp1_valid;
  logic          rsp1_ready = 1'b0;
  logic [DW-1:0] rsp1_data;

  int n_checks = 0;
  int n_pass   = 0;

  mult_share_arb #(
    .bw     (BW),
    .LAT    (LAT),
    .RDEPTH (RDEPTH)
  ) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_A     (req0_A),
    .req0_B     (req0_B),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_A     (req1_A),
    .req1_B     (req1_B),
    .mul_A      (mul_A),
    .mul_B      (mul_B),
    .mul_out    (mul_out),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data)
  );

  always #5 CLK = ~CLK;

  // Stand-in for multiplier_array_pipe: product of the operand registers appears LAT edges after they load.
  logic [DW-1:0] mp [LAT];
  always @(posedge CLK) begin
    mp[0] <= {{BW{1'b0}}, mul_A} * {{BW{1'b0}}, mul_B};
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_out = mp[LAT-1];

  // Reference model: outstanding count per requester and a queue of (product, visible-from-cycle).
  typedef struct {
    int unsigned prod;
    int unsigned arrive;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          out0 = 0;
  int          out1 = 0;
  int          lastg = 1;
  int unsigned cyc = 0;
  int unsigned m_a = 0;
  int unsigned m_b = 0;

  function automatic logic [1:0] exp_grant();
    logic e0, e1;
    e0 = req0_valid && (out0 < RDEPTH);
    e1 = req1_valid && (out1 < RDEPTH);
`ifdef MULT_ARB_FIXED_PRIO_EN
    if (e0) return 2'b01;
    return {e1, 1'b0};
`else
    if (e0 && e1) return (lastg == 0) ? 2'b10 : 2'b01;
    return {e1, e0};
`endif
  endfunction

  function automatic logic exp_vld(input int id);
    if (id == 0) return (q0.size() != 0) && (q0[0].arrive <= cyc);
    return (q1.size() != 0) && (q1[0].arrive <= cyc);
  endfunction

  function automatic int unsigned exp_dat(input int id);
    if (!exp_vld(id)) return 0;
    return (id == 0) ? q0[0].prod : q1[0].prod;
  endfunction

  always @(posedge CLK or negedge RESETn) begin : model
    logic [1:0] g;
    logic       p0, p1;
    exp_t       e;
    if (!RESETn) begin
      q0.delete();
      q1.delete();
      out0  = 0;
      out1  = 0;
      lastg = 1;
      m_a   = 0;
      m_b   = 0;
    end else begin
      g  = exp_grant();
      p0 = exp_vld(0) && rsp0_ready;
      p1 = exp_vld(1) && rsp1_ready;
      cyc = cyc + 1;
      if (p0) begin void'(q0.pop_front()); out0--; end
      if (p1) begin void'(q1.pop_front()); out1--; end
      if (g[0]) begin
        e.prod = 32'(req0_A) * 32'(req0_B);
        e.arrive = cyc + LAT + 1;
        q0.push_back(e);
        out0++;
        lastg = 0;
        m_a = 32'(req0_A);
        m_b = 32'(req0_B);
      end else if (g[1]) begin
        e.prod = 32'(req1_A) * 32'(req1_B);
        e.arrive = cyc + LAT + 1;
        q1.push_back(e);
        out1++;
        lastg = 1;
        m_a = 32'(req1_A);
        m_b = 32'(req1_B);
      end
    end
  end

  task automatic do_reset();
    RESETn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_A = '0; req0_B = '0; req1_A = '0; req1_B = '0;
    @(posedge CLK);
    @(posedge CLK);
    #1 RESETn = 1'b1;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (mul_A !== '0 || mul_B !== '0) $display("[TB] FAIL reset_mul actual=%0d/%0d expected=0/0", mul_A, mul_B);
    else n_pass++;
    n_checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) $display("[TB] FAIL reset_valid actual=%b%b expected=00", rsp1_valid, rsp0_valid);
    else n_pass++;
    n_checks++;
    if (rsp0_data !== '0 || rsp1_data !== '0) $display("[TB] FAIL reset_data actual=%0d/%0d expected=0/0", rsp0_data, rsp1_data);
    else n_pass++;
    @(posedge CLK);
    #1 RESETn = 1'b1;
    req0_valid = 1'b1; req0_A = 8'd200; req0_B = 8'd3;
    req1_valid = 1'b1; req1_A = 8'd17;  req1_B = 8'd4;
    @(negedge CLK);
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01) $display("[TB] FAIL first_tie actual=%b expected=01", {req1_ready, req0_ready});
    else n_pass++;
    @(posedge CLK);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (mul_A !== 8'd200 || mul_B !== 8'd3) $display("[TB] FAIL first_issue_mul actual=%0d/%0d expected=200/3", mul_A, mul_B);
    else n_pass++;
  endtask

  task automatic test_single();
    int edges;
    logic seen;
    do_reset();
    req0_A = 8'd118; req0_B = 8'd181; req0_valid = 1'b1; rsp0_ready = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (req0_ready !== 1'b1) $display("[TB] FAIL single_ready actual=%b expected=1", req0_ready);
    else n_pass++;
    @(posedge CLK);
    #1 req0_valid = 1'b0;
    edges = 0; seen = 1'b0;
    while (!seen && edges < 4 * LAT) begin
      @(posedge CLK);
      #1 edges++;
      if (rsp0_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || edges != LAT + 1) $display("[TB] FAIL single_latency actual=%0d seen=%b expected=%0d", edges, seen, LAT + 1);
    else n_pass++;
    n_checks++;
    if (rsp0_data !== 16'd21358) $display("[TB] FAIL single_data actual=%0d expected=21358", rsp0_data);
    else n_pass++;
    @(posedge CLK);
    #1;
    n_checks++;
    if (rsp0_valid !== 1'b0) $display("[TB] FAIL single_popped actual=%b expected=0", rsp0_valid);
    else n_pass++;
  endtask

  task automatic test_alternate();
    logic [1:0] g;
    int pops0, pops1, iss0, iss1;
    pops0 = 0; pops1 = 0; iss0 = 0; iss1 = 0;
    do_reset();
    req0_A = 8'd119; req0_B = 8'd182; req1_A = 8'd3; req1_B = 8'd5;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int c = 0; c < 48 + 2 * LAT; c++) begin
      if (c == 48) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge CLK);
      g = exp_grant();
      n_checks++;
      if ({req1_ready, req0_ready} !== g) $display("[TB] FAIL alt_grant c=%0d actual=%b expected=%b", c, {req1_ready, req0_ready}, g);
      else n_pass++;
`ifndef MULT_ARB_FIXED_PRIO_EN
      if (c < 2 * RDEPTH) begin
        n_checks++;
        if ({req1_ready, req0_ready} !== ((c % 2 == 0) ? 2'b01 : 2'b10))
          $display("[TB] FAIL alt_pattern c=%0d actual=%b expected=%b", c, {req1_ready, req0_ready}, (c % 2 == 0) ? 2'b01 : 2'b10);
        else n_pass++;
      end
`endif
      n_checks++;
      if (rsp0_valid !== exp_vld(0) || (rsp0_valid === 1'b1 && rsp0_data !== 16'd21658))
        $display("[TB] FAIL alt_rsp0 c=%0d actual=%b/%0d expected=%b/21658", c, rsp0_valid, rsp0_data, exp_vld(0));
      else n_pass++;
      n_checks++;
      if (rsp1_valid !== exp_vld(1) || (rsp1_valid === 1'b1 && rsp1_data !== 16'd15))
        $display("[TB] FAIL alt_rsp1 c=%0d actual=%b/%0d expected=%b/15", c, rsp1_valid, rsp1_data, exp_vld(1));
      else n_pass++;
      if (req0_ready === 1'b1) iss0++;
      if (req1_ready === 1'b1) iss1++;
      if (rsp0_valid === 1'b1) pops0++;
      if (rsp1_valid === 1'b1) pops1++;
      @(posedge CLK);
      #1;
    end
    n_checks++;
    if (pops0 != iss0 || pops1 != iss1 || iss0 == 0 || iss1 == 0)
      $display("[TB] FAIL alt_counts actual pops=%0d/%0d expected issues=%0d/%0d", pops0, pops1, iss0, iss1);
    else n_pass++;
  endtask

  task automatic test_credit_stall();
    logic [1:0] g;
    logic fire0;
    int i, iss0, npop;
    i = 1; iss0 = 0; npop = 0;
    do_reset();
    req0_A = 8'd1; req0_B = 8'd2; req0_valid = 1'b1;
    req1_A = BW'($urandom); req1_B = BW'($urandom); req1_valid = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (c == 30) rsp0_ready = 1'b1;
      @(negedge CLK);
      g = exp_grant();
      n_checks++;
      if ({req1_ready, req0_ready} !== g) $display("[TB] FAIL stall_grant c=%0d actual=%b expected=%b", c, {req1_ready, req0_ready}, g);
      else n_pass++;
      n_checks++;
      if (rsp0_valid !== exp_vld(0) || rsp0_data !== DW'(exp_dat(0)))
        $display("[TB] FAIL stall_rsp0 c=%0d actual=%b/%0d expected=%b/%0d", c, rsp0_valid, rsp0_data, exp_vld(0), exp_dat(0));
      else n_pass++;
      n_checks++;
      if (rsp1_valid !== exp_vld(1) || rsp1_data !== DW'(exp_dat(1)))
        $display("[TB] FAIL stall_rsp1 c=%0d actual=%b/%0d expected=%b/%0d", c, rsp1_valid, rsp1_data, exp_vld(1), exp_dat(1));
      else n_pass++;
      fire0 = (req0_ready === 1'b1);
      if (fire0) iss0++;
      if (c == 29) begin
        n_checks++;
        if (iss0 != RDEPTH || req0_ready !== 1'b0) $display("[TB] FAIL stall_issues actual=%0d ready=%b expected=%0d ready=0", iss0, req0_ready, RDEPTH);
        else n_pass++;
      end
      if (rsp0_valid === 1'b1 && rsp0_ready === 1'b1 && npop < 4) begin
        n_checks++;
        if (rsp0_data !== DW'((npop + 1) * (npop + 2)))
          $display("[TB] FAIL stall_drain n=%0d actual=%0d expected=%0d", npop, rsp0_data, (npop + 1) * (npop + 2));
        else n_pass++;
        npop++;
      end
      @(posedge CLK);
      #1;
      if (fire0) begin i++; req0_A = BW'(i); req0_B = BW'(i + 1); end
      req1_A = BW'($urandom); req1_B = BW'($urandom);
    end
    n_checks++;
    if (npop != 4) $display("[TB] FAIL stall_drain_count actual=%0d expected=4", npop);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [1:0] g;
    int iss0, rcv, c;
    iss0 = 0; rcv = 0; c = 0;
    do_reset();
    req0_A = BW'($urandom); req0_B = BW'($urandom); req0_valid = 1'b1;
    while (rcv < 3 * RDEPTH && c < 400) begin
      rsp0_ready = c[0];
      @(negedge CLK);
      g = exp_grant();
      n_checks++;
      if ({req1_ready, req0_ready} !== g) $display("[TB] FAIL wrap_grant c=%0d actual=%b expected=%b", c, {req1_ready, req0_ready}, g);
      else n_pass++;
      n_checks++;
      if (rsp0_valid !== exp_vld(0) || rsp0_data !== DW'(exp_dat(0)))
        $display("[TB] FAIL wrap_rsp0 c=%0d actual=%b/%0d expected=%b/%0d", c, rsp0_valid, rsp0_data, exp_vld(0), exp_dat(0));
      else n_pass++;
      if (req0_ready === 1'b1) iss0++;
      if (rsp0_valid === 1'b1 && rsp0_ready === 1'b1) rcv++;
      @(posedge CLK);
      #1;
      if (iss0 >= 3 * RDEPTH) req0_valid = 1'b0;
      req0_A = BW'($urandom); req0_B = BW'($urandom);
      c++;
    end
    n_checks++;
    if (rcv != 3 * RDEPTH) $display("[TB] FAIL wrap_count actual=%0d expected=%0d", rcv, 3 * RDEPTH);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int iss0, c, edges;
    logic seen;
    iss0 = 0; c = 0;
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_A = BW'($urandom); req0_B = BW'($urandom); req0_valid = 1'b1;
    while (iss0 < 3 && c < 20) begin
      @(negedge CLK);
      if (req0_ready === 1'b1) iss0++;
      @(posedge CLK);
      #1;
      if (iss0 >= 3) req0_valid = 1'b0;
      req0_A = BW'($urandom); req0_B = BW'($urandom);
      c++;
    end
    repeat (LAT / 2 - 1) @(posedge CLK);
    #1 RESETn = 1'b0;
    #1;
    n_checks++;
    if (mul_A !== '0 || mul_B !== '0 || rsp0_valid !== 1'b0 || rsp0_data !== '0 || rsp1_valid !== 1'b0)
      $display("[TB] FAIL midreset_outputs actual=%0d/%0d/%b/%0d/%b expected=0/0/0/0/0", mul_A, mul_B, rsp0_valid, rsp0_data, rsp1_valid);
    else n_pass++;
    @(posedge CLK);
    #1 RESETn = 1'b1;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge CLK);
      n_checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) $display("[TB] FAIL midreset_ghost k=%0d actual=%b%b expected=00", k, rsp1_valid, rsp0_valid);
      else n_pass++;
    end
    @(posedge CLK);
    #1 req0_A = 8'd7; req0_B = 8'd9; req0_valid = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (req0_ready !== 1'b1) $display("[TB] FAIL midreset_ready actual=%b expected=1", req0_ready);
    else n_pass++;
    @(posedge CLK);
    #1 req0_valid = 1'b0;
    edges = 0; seen = 1'b0;
    while (!seen && edges < 4 * LAT) begin
      @(posedge CLK);
      #1 edges++;
      if (rsp0_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || edges != LAT + 1 || rsp0_data !== 16'd63)
      $display("[TB] FAIL midreset_result actual=%0d after %0d edges expected=63 after %0d", rsp0_data, edges, LAT + 1);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] g;
    do_reset();
    for (int c = 0; c < 300 + 3 * LAT; c++) begin
      if (c < 300) begin
        req0_valid = ($urandom_range(0, 9) < 7);
        req1_valid = ($urandom_range(0, 9) < 7);
        rsp0_ready = ($urandom_range(0, 9) < 6);
        rsp1_ready = ($urandom_range(0, 9) < 6);
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      end
      req0_A = BW'($urandom); req0_B = BW'($urandom);
      req1_A = BW'($urandom); req1_B = BW'($urandom);
      @(negedge CLK);
      g = exp_grant();
      n_checks++;
      if ({req1_ready, req0_ready} !== g) $display("[TB] FAIL rand_grant c=%0d actual=%b expected=%b", c, {req1_ready, req0_ready}, g);
      else n_pass++;
      n_checks++;
      if (rsp0_valid !== exp_vld(0) || rsp0_data !== DW'(exp_dat(0)))
        $display("[TB] FAIL rand_rsp0 c=%0d actual=%b/%0d expected=%b/%0d", c, rsp0_valid, rsp0_data, exp_vld(0), exp_dat(0));
      else n_pass++;
      n_checks++;
      if (rsp1_valid !== exp_vld(1) || rsp1_data !== DW'(exp_dat(1)))
        $display("[TB] FAIL rand_rsp1 c=%0d actual=%b/%0d expected=%b/%0d", c, rsp1_valid, rsp1_data, exp_vld(1), exp_dat(1));
      else n_pass++;
      n_checks++;
      if (32'(mul_A) !== m_a || 32'(mul_B) !== m_b) $display("[TB] FAIL rand_mul c=%0d actual=%0d/%0d expected=%0d/%0d", c, mul_A, mul_B, m_a, m_b);
      else n_pass++;
      @(posedge CLK);
      #1;
    end
  endtask

`ifdef MULT_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int c = 0; c < RDEPTH; c++) begin
      @(negedge CLK);
      n_checks++;
      if ({req1_ready, req0_ready} !== 2'b01) $display("[TB] FAIL fixed_prio c=%0d actual=%b expected=01", c, {req1_ready, req0_ready});
      else n_pass++;
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b10) $display("[TB] FAIL fixed_starve_gap actual=%b expected=10", {req1_ready, req0_ready});
    else n_pass++;
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_credit_stall();
    test_wrap();
    test_reset_midflight();
    test_random();
`ifdef MULT_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
